serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 31 +++
 rtl/full_subtractor_cell.sv | 26 ++
 rtl/serial_subtractor.sv | 174 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared types and helpers for the bit-serial subtractor.
//                - state_t   : control FSM encoding (IDLE, CALC, DONE)
//                - cnt_w()   : bit-counter width for a given operand width
//                - width_ok(): legality check for the WIDTH parameter
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int C_MIN_WIDTH = 1;
    localparam int C_MAX_WIDTH = 32;

    // Counter wide enough to hold 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic bit width_ok(input int width);
        return (width >= C_MIN_WIDTH) && (width <= C_MAX_WIDTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor_cell.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor_cell
//  Description : One-bit full subtractor, computes x - y - bin.
//  Ports       : x    in  minuend bit
//                y    in  subtrahend bit
//                bin  in  borrow in
//                d    out difference bit
//                bout out borrow out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y exceeds x outright, or when they are equal and a borrow
    // is already pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor, diff = a - b mod 2^WIDTH.
//                Operands are shifted out LSB first through a single
//                full-subtractor cell and one borrow flip-flop; a result
//                takes WIDTH clocks in CALC.
//  Ports       : clk        in  clock, rising edge
//                rst_n      in  asynchronous active-low reset
//                in_valid   in  operand pair valid
//                in_ready   out operands accepted (IDLE only)
//                a, b       in  minuend / subtrahend (WIDTH bits)
//                out_valid  out result valid (DONE)
//                out_ready  in  consumer takes result
//                diff       out a - b mod 2^WIDTH
//                borrow_out out 1 iff a < b
//                zero       out diff == 0
//                busy       out high in CALC and DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             busy
);

    localparam int                 C_CNT_W = cnt_w(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    generate
        if (!width_ok(WIDTH)) begin : g_width_illegal
            $fatal(1, "serial_subtractor: WIDTH must be in 1..32");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_borrow;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;
    logic               r_zero;

    logic               w_d;
    logic               w_bout;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;

    full_subtractor_cell u_cell (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // The new difference bit enters at the MSB; after WIDTH shifts the
    // first (LSB) bit has arrived at position 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (r_state == CALC) && (r_cnt == C_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_res    <= '0;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                    end
                end
                CALC: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res    <= w_res_next;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + C_ONE;
                    // Result registers only change here, so they hold
                    // through DONE and after the output handshake.
                    if (w_last) begin
                        r_diff       <= w_res_next;
                        r_borrow_out <= w_bout;
                        r_zero       <= (w_res_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign zero       = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Scoreboard bench for serial_subtractor, WIDTH=4 and WIDTH=1
//                instances. Stimulus pushes hand-computed expected results;
//                per-instance monitors pop and compare on output handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    typedef struct {
        logic [3:0] d;
        logic       bo;
        logic       z;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         edges = 0;
    int         checks = 0;
    int         errors = 0;

    // WIDTH=4 instance
    logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b1, bo4, z4, busy4;
    logic [3:0] a4 = '0, b4 = '0, d4;
    exp_t       q4[$];
    logic       pv4 = 1'b0;

    // WIDTH=1 instance
    logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b1, bo1, z1, busy1;
    logic [0:0] a1 = '0, b1 = '0, d1;
    exp_t       q1[$];
    logic       pv1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4),
        .diff(d4), .borrow_out(bo4), .zero(z4), .busy(busy4)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1),
        .diff(d1), .borrow_out(bo1), .zero(z1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------ monitors
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov4) begin
                if (q4.size() == 0) begin
                    fail("unexpected_out4");
                end else begin
                    if (!pv4) chk("latency4", edges - q4[0].acc, 4);
                    chk("diff4", d4, q4[0].d);
                    chk("borrow4", bo4, q4[0].bo);
                    chk("zero4", z4, q4[0].z);
                    chk("busy4_done", busy4, 1);
                    chk("in_ready4_done", ir4, 0);
                    if (or4) void'(q4.pop_front());
                end
            end
            pv4 <= ov4;
        end else begin
            pv4 <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov1) begin
                if (q1.size() == 0) begin
                    fail("unexpected_out1");
                end else begin
                    if (!pv1) chk("latency1", edges - q1[0].acc, 1);
                    chk("diff1", d1, q1[0].d);
                    chk("borrow1", bo1, q1[0].bo);
                    chk("zero1", z1, q1[0].z);
                    if (or1) void'(q1.pop_front());
                end
            end
            pv1 <= ov1;
        end else begin
            pv1 <= 1'b0;
        end
    end

    // --------------------------------------------------- stimulus helpers
    // All stimulus runs 2 ns after a rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic bo, input logic z);
        int n = 0;
        a4 = a; b4 = b; iv4 = 1'b1;
        while (!ir4 && n < 20) begin tick(); n++; end
        if (!ir4) begin
            fail("accept_timeout4");
        end else begin
            q4.push_back('{d: d, bo: bo, z: z, acc: edges + 1});
            tick();
        end
        iv4 = 1'b0;
    endtask

    // Waits for out_valid, checking busy/in_ready while computing.
    task automatic wait_out4(input string name);
        int n = 0;
        while (!ov4 && n < 10) begin
            chk({name, "_busy"}, busy4, 1);
            chk({name, "_in_ready"}, ir4, 0);
            tick(); n++;
        end
        if (!ov4) fail({name, "_valid_timeout"});
    endtask

    task automatic drain(input int timeout);
        int n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < timeout) begin tick(); n++; end
        if (q4.size() != 0 || q1.size() != 0) begin
            fail("drain_timeout");
            q4.delete();
            q1.delete();
        end
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int accs[3];
        int idx;
        int n;
        logic [0:0] pa[3];
        logic [0:0] pb[3];
        logic [3:0] pd[3];
        logic       pbo[3];
        logic       pz[3];

        repeat (2) tick();
        chk("rst_in_ready", ir4, 1);
        chk("rst_out_valid", ov4, 0);
        chk("rst_diff", d4, 0);
        chk("rst_borrow", bo4, 0);
        chk("rst_zero", z4, 0);
        chk("rst_busy", busy4, 0);
        rst_n = 1'b1;

        // Basic subtraction with busy/latency check
        send4(4'd9, 4'd3, 4'd6, 1'b0, 1'b0);
        wait_out4("basic");
        drain(10);

        send4(4'd7, 4'd7, 4'd0, 1'b0, 1'b1);
        drain(10);
        send4(4'd15, 4'd0, 4'd15, 1'b0, 1'b0);
        drain(10);

        // Backpressure: result must hold, in_valid/a/b ignored until handshake
        or4 = 1'b0;
        send4(4'd13, 4'd6, 4'd7, 1'b0, 1'b0);
        a4 = 4'd1; b4 = 4'd1;
        n = 0;
        while (!ov4 && n < 10) begin
            iv4 = ~iv4;
            chk("bp_in_ready_calc", ir4, 0);
            tick(); n++;
        end
        if (!ov4) fail("bp_valid_timeout");
        repeat (5) begin
            iv4 = ~iv4;
            chk("bp_in_ready_done", ir4, 0);
            chk("bp_valid_held", ov4, 1);
            tick();
        end
        // Keep 1-1 offered: it may only be taken after the result handshake.
        iv4 = 1'b1; or4 = 1'b1;
        q4.push_back('{d: 4'd0, bo: 1'b0, z: 1'b1, acc: edges + 2});
        tick();
        chk("bp_valid_dropped", ov4, 0);
        chk("bp_in_ready_idle", ir4, 1);
        tick();
        iv4 = 1'b0;
        chk("bp_accepted", busy4, 1);
        drain(10);

        send4(4'd3, 4'd9, 4'd10, 1'b1, 1'b0);
        drain(10);

        // Reset two cycles into CALC
        send4(4'd5, 4'd10, 4'd11, 1'b1, 1'b0);
        tick();
        tick();
        chk("pre_reset_busy", busy4, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", ov4, 0);
        chk("mid_rst_busy", busy4, 0);
        chk("mid_rst_diff", d4, 0);
        chk("mid_rst_borrow", bo4, 0);
        chk("mid_rst_in_ready", ir4, 1);
        q4.delete();
        tick();
        rst_n = 1'b1;
        send4(4'd12, 4'd5, 4'd7, 1'b0, 1'b0);
        drain(10);
        send4(4'd0, 4'd15, 4'd1, 1'b1, 1'b0);
        drain(10);

        // WIDTH=1 back-to-back
        pa = '{1'b1, 1'b0, 1'b1};
        pb = '{1'b0, 1'b1, 1'b1};
        pd = '{4'd1, 4'd1, 4'd0};
        pbo = '{1'b0, 1'b1, 1'b0};
        pz = '{1'b0, 1'b0, 1'b1};
        or1 = 1'b1;
        idx = 0;
        n = 0;
        a1 = pa[0]; b1 = pb[0]; iv1 = 1'b1;
        while (idx < 3 && n < 30) begin
            if (ir1) begin
                q1.push_back('{d: pd[idx], bo: pbo[idx], z: pz[idx], acc: edges + 1});
                accs[idx] = edges + 1;
                idx++;
                tick();
                if (idx < 3) begin
                    a1 = pa[idx]; b1 = pb[idx];
                end else begin
                    iv1 = 1'b0;
                end
            end else begin
                tick();
            end
            n++;
        end
        iv1 = 1'b0;
        if (idx < 3) begin
            fail("w1_accept_timeout");
        end else begin
            chk("w1_spacing_01", accs[1] - accs[0], 3);
            chk("w1_spacing_12", accs[2] - accs[1], 3);
        end
        drain(10);

        chk("q4_empty", q4.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
